// File: rtl/aud_pkg.sv
// aud_pkg: shared state encoding and default sizes for the audio recorder and player
package aud_pkg;
  typedef enum logic [2:0] {S_IDLE, S_WAIT, S_SHIFT, S_WRITE, S_PAUSE} state_e;
  localparam int unsigned DEF_DATA_W = 16;
  localparam int unsigned DEF_ADDR_W = 20;
  localparam logic [DEF_ADDR_W-1:0] DEF_MAX_ADDR = 20'hFFFFF;
endpackage

// File: rtl/aud_recorder_if.sv
// aud_recorder_if: SRAM write port carrying address, data and a one-cycle write strobe
interface aud_recorder_if import aud_pkg::*; #(
  parameter int unsigned DATA_W = DEF_DATA_W,
  parameter int unsigned ADDR_W = DEF_ADDR_W
);
  logic [ADDR_W-1:0] address;
  logic [DATA_W-1:0] data;
  logic wr;
  modport master (output address, data, wr);
  modport slave (input address, data, wr);
endinterface

// File: rtl/i2s_deser.sv
// i2s_deser: I2S frame-start detect and MSB-first shift register with bit counter
module i2s_deser import aud_pkg::*; #(
  parameter int unsigned DATA_W = DEF_DATA_W
) (
  input  logic              i_clk,
  input  logic              i_rst_n,
  input  logic              i_en,
  input  logic              i_lrc,
  input  logic              i_dat,
  output logic              o_fs,
  output logic              o_last,
  output logic              o_sample_vld,
  output logic [DATA_W-1:0] o_sample
);
  localparam int unsigned CW = $clog2(DATA_W);
  logic lrc_q, lrc_d, vld_q, vld_d;
  logic [CW-1:0] bit_cnt_q, bit_cnt_d;
  logic [DATA_W-1:0] shreg_q, shreg_d;
  always_comb begin
    lrc_d = i_lrc;
    o_fs = lrc_q && !i_lrc;
    o_last = i_en && bit_cnt_q == CW'(DATA_W-1);
    vld_d = o_last;
    bit_cnt_d = i_en ? bit_cnt_q + 1'b1 : '0;
    shreg_d = i_en ? {shreg_q[DATA_W-2:0], i_dat} : shreg_q;
  end
  always_ff @(posedge i_clk or negedge i_rst_n)
    if (!i_rst_n) begin
      lrc_q <= 1'b1;
      vld_q <= 1'b0;
      bit_cnt_q <= '0;
      shreg_q <= '0;
    end else begin
      lrc_q <= lrc_d;
      vld_q <= vld_d;
      bit_cnt_q <= bit_cnt_d;
      shreg_q <= shreg_d;
    end
  assign o_sample_vld = vld_q;
  assign o_sample = shreg_q;
endmodule

// File: rtl/aud_recorder.sv
// aud_recorder: captures left-channel I2S samples and emits one SRAM write per sample
module aud_recorder import aud_pkg::*; #(
  parameter int unsigned DATA_W = DEF_DATA_W,
  parameter int unsigned ADDR_W = DEF_ADDR_W,
  parameter logic [ADDR_W-1:0] MAX_ADDR = ADDR_W'(DEF_MAX_ADDR)
) (
  input  logic              i_clk,
  input  logic              i_rst_n,
  input  logic              i_init_done,
  input  logic              i_start,
  input  logic              i_pause,
  input  logic              i_stop,
  input  logic              i_lrc,
  input  logic              i_dat,
  aud_recorder_if.master    wr_if,
  output logic              o_busy,
  output logic              o_full,
  output logic [ADDR_W:0]   o_len
);
  localparam logic [ADDR_W:0] LEN_MAX = {1'b0, MAX_ADDR} + 1'b1;
  state_e state_q, state_d;
  logic [ADDR_W-1:0] addr_q, addr_d, o_address_q, o_address_d;
  logic [ADDR_W:0] len_q, len_d;
  logic [DATA_W-1:0] o_data_q, o_data_d, sample;
  logic full_q, full_d, stop_pend_q, stop_pend_d, pause_pend_q, pause_pend_d, o_wr_q, o_wr_d;
  logic fs, last, smp_vld, stop_ev, stop_now, pause_now, wr, keep;
  i2s_deser #(.DATA_W(DATA_W)) u_deser (
    .i_clk        (i_clk),
    .i_rst_n      (i_rst_n),
    .i_en         (state_q == S_SHIFT),
    .i_lrc        (i_lrc),
    .i_dat        (i_dat),
    .o_fs         (fs),
    .o_last       (last),
    .o_sample_vld (smp_vld),
    .o_sample     (sample)
  );
  always_comb begin
    stop_ev = i_stop || !i_init_done;
    stop_now = stop_pend_q || stop_ev;
    pause_now = pause_pend_q || i_pause;
    wr = state_q == S_WRITE && smp_vld;
    state_d = state_q;
    addr_d = addr_q;
    len_d = len_q;
    full_d = full_q;
    o_wr_d = wr;
    o_data_d = wr ? sample : o_data_q;
    o_address_d = wr ? addr_q : o_address_q;
    case (state_q)
      S_IDLE: if (i_start && i_init_done && !i_stop) begin
        state_d = S_WAIT;
        addr_d = '0;
        len_d = '0;
        full_d = 1'b0;
        o_address_d = '0;
      end
      S_WAIT: state_d = stop_ev ? S_IDLE : i_pause ? S_PAUSE : fs ? S_SHIFT : S_WAIT;
      S_SHIFT: state_d = last ? S_WRITE : S_SHIFT;
      S_WRITE: begin
        len_d = len_q == LEN_MAX ? len_q : len_q + 1'b1;
        full_d = full_q || addr_q == MAX_ADDR;
        addr_d = addr_q == MAX_ADDR ? addr_q : addr_q + 1'b1;
        state_d = (addr_q == MAX_ADDR || stop_now) ? S_IDLE : pause_now ? S_PAUSE : S_WAIT;
      end
      S_PAUSE: state_d = stop_ev ? S_IDLE : (i_start && !i_pause) ? S_WAIT : S_PAUSE;
      default: state_d = S_IDLE;
    endcase
    keep = state_d == S_SHIFT || state_d == S_WRITE;
    stop_pend_d = keep && stop_now;
    pause_pend_d = keep && pause_now;
  end
  always_ff @(posedge i_clk or negedge i_rst_n)
    if (!i_rst_n) begin
      state_q <= S_IDLE;
      addr_q <= '0;
      len_q <= '0;
      full_q <= 1'b0;
      stop_pend_q <= 1'b0;
      pause_pend_q <= 1'b0;
      o_wr_q <= 1'b0;
      o_data_q <= '0;
      o_address_q <= '0;
    end else begin
      state_q <= state_d;
      addr_q <= addr_d;
      len_q <= len_d;
      full_q <= full_d;
      stop_pend_q <= stop_pend_d;
      pause_pend_q <= pause_pend_d;
      o_wr_q <= o_wr_d;
      o_data_q <= o_data_d;
      o_address_q <= o_address_d;
    end
  assign wr_if.wr = o_wr_q;
  assign wr_if.data = o_data_q;
  assign wr_if.address = o_address_q;
  assign o_busy = state_q != S_IDLE;
  assign o_full = full_q;
  assign o_len = len_q;
endmodule
